// File: rtl/seg_scan_display.sv
// seg_scan_display
// Six-digit multiplexed seven-segment display driver for a common-anode
// display. It lights one digit at a time, blanks between digits, latches
// all six digits at once at the end of each frame so that a frame never
// mixes old and new digits, and blinks the whole display while an alarm
// flash request is active.
//
// Ports:
//   true_clk    free-running clock, all state on the rising edge
//   clr         asynchronous active-low reset
//   d1..d6      4-bit digit codes, d1 = leftmost digit
//   flash       alarm blink request, asynchronous to the display timing
//   ok          unlock indicator, lights the decimal points
//   an[5:0]     digit enables, active-low, an[0] = d1
//   seg[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  one-cycle pulse at the start of each frame
//
// Blink phase:
//   state   | meaning
//   PH_ON   | display shows the scanned digits
//   PH_OFF  | display dark; scanning and capture keep running

module seg_scan_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic       true_clk,
  input  logic       clr,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       flash,
  input  logic       ok,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  // +1 keeps the width at least one bit when BLINK_DIV is 1
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [3:0]       sh1, sh2, sh3, sh4, sh5, sh6;
  logic             flash_meta;
  logic             flash_s;
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_nxt;
  phase_t           phase;
  phase_t           phase_nxt;

  logic             slot_wrap;
  logic             capture;
  logic             lit;
  logic [3:0]       cur_code;
  logic [5:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b1111111;
    case (code)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA, 4'hB, 4'hC, 4'hD: g = 7'b0111111;
      4'hE: g = 7'b0000110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign slot_wrap = (cnt == CNT_W'(SCAN_DIV - 1));
  // Last cycle of the last slot: latch the next frame's digits here
  assign capture   = slot_wrap && (idx == 3'd5);

  // Blink control
  always_comb begin
    phase_nxt = phase;
    blk_nxt   = blk_cnt;
    if (!flash_s) begin
      phase_nxt = PH_ON;
      blk_nxt   = '0;
    end else if (slot_wrap) begin
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_nxt   = '0;
        phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blk_nxt = blk_cnt + 1'b1;
      end
    end
  end

  // Output selection from the current scan state
  always_comb begin
    cur_code = 4'hF;
    case (idx)
      3'd0: cur_code = sh1;
      3'd1: cur_code = sh2;
      3'd2: cur_code = sh3;
      3'd3: cur_code = sh4;
      3'd4: cur_code = sh5;
      3'd5: cur_code = sh6;
      default: cur_code = 4'hF;
    endcase
  end

  always_comb begin
    lit     = (cnt != '0) && (phase == PH_ON);
    an_nxt  = 6'b111111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt  = ~(6'b000001 << idx);
      seg_nxt = glyph(cur_code);
      dp_nxt  = ~ok;
    end
  end

  always_ff @(posedge true_clk or negedge clr) begin
    if (!clr) begin
      cnt        <= '0;
      idx        <= 3'd0;
      sh1        <= 4'hF;
      sh2        <= 4'hF;
      sh3        <= 4'hF;
      sh4        <= 4'hF;
      sh5        <= 4'hF;
      sh6        <= 4'hF;
      flash_meta <= 1'b0;
      flash_s    <= 1'b0;
      blk_cnt    <= '0;
      phase      <= PH_ON;
      an         <= 6'b111111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      flash_meta <= flash;
      flash_s    <= flash_meta;
      blk_cnt    <= blk_nxt;
      phase      <= phase_nxt;

      if (slot_wrap) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (capture) begin
        sh1 <= d1;
        sh2 <= d2;
        sh3 <= d3;
        sh4 <= d4;
        sh5 <= d5;
        sh6 <= d6;
      end

      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= capture;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int SD = 4;
  localparam int BD = 3;
  localparam int FR = SD * 6;

  logic       true_clk;
  logic       clr;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic       flash;
  logic       ok;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .true_clk  (true_clk),
    .clr       (clr),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .flash     (flash),
    .ok        (ok),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  initial true_clk = 1'b0;
  always #5 true_clk = ~true_clk;

  // Reference model: time since reset release, frame-latched digits,
  // delayed flash, and number of slot ends seen while blinking.
  int         m_t;
  int         p_t;
  logic [3:0] m_sh [6];
  bit         m_f1, m_fs;
  int         m_wraps;
  int         last_fd;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } glyph_vec_t;

  glyph_vec_t vecs [16];

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hE: return 7'b0000110;
      4'hF: return 7'b1111111;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 6; i++) m_sh[i] = 4'hF;
    m_f1 = 0;
    m_fs = 0;
    m_wraps = 0;
    last_fd = -1;
  endtask

  // One clock: predict the registered outputs from the pre-edge state,
  // advance the model, then compare just after the edge.
  task automatic step();
    int c, ix;
    bit ph_on, lt;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    @(posedge true_clk);
    c     = m_t % SD;
    ix    = (m_t / SD) % 6;
    ph_on = ((m_wraps / BD) % 2) == 0;
    lt    = (c != 0) && ph_on;
    e_an  = lt ? ~(6'b000001 << ix) : 6'b111111;
    e_seg = lt ? ref_glyph(m_sh[ix]) : 7'b1111111;
    e_dp  = (lt && ok) ? 1'b0 : 1'b1;
    e_fd  = (m_t % FR) == FR - 1;
    if (!m_fs) m_wraps = 0;
    else if (c == SD - 1) m_wraps++;
    m_fs = m_f1;
    m_f1 = flash;
    if ((m_t % FR) == FR - 1) begin
      m_sh[0] = d1; m_sh[1] = d2; m_sh[2] = d3;
      m_sh[3] = d4; m_sh[4] = d5; m_sh[5] = d6;
    end
    p_t = m_t;
    m_t++;
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_done", frame_done, e_fd);
    chk("one_anode", ($countones(~an) <= 1), 1);
    if (frame_done) begin
      if (last_fd >= 0) chk("fd_period", m_t - last_fd, FR);
      last_fd = m_t;
    end
    @(negedge true_clk);
  endtask

  // Step until the outputs just sampled reflect slot (i, c)
  task automatic run_to_slot(input int i, input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((p_t % FR) != i * SD + c) && n < 200);
    if (n >= 200) chk("run_to_slot_timeout", n, 0);
  endtask

  task automatic set_all(input logic [3:0] c);
    d1 = c; d2 = c; d3 = c; d4 = c; d5 = c; d6 = c;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k].code = 4'(k);
      vecs[k].seg  = 7'b0111111;
    end
    vecs[0].seg  = 7'b1000000; vecs[1].seg  = 7'b1111001;
    vecs[2].seg  = 7'b0100100; vecs[3].seg  = 7'b0110000;
    vecs[4].seg  = 7'b0011001; vecs[5].seg  = 7'b0010010;
    vecs[6].seg  = 7'b0000010; vecs[7].seg  = 7'b1111000;
    vecs[8].seg  = 7'b0000000; vecs[9].seg  = 7'b0010000;
    vecs[14].seg = 7'b0000110; vecs[15].seg = 7'b1111111;

    clr = 1'b0; flash = 1'b0; ok = 1'b0;
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; d5 = 4'd5; d6 = 4'd6;
    repeat (2) @(negedge true_clk);
    chk("rst_an", an, 6'b111111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    clr = 1'b1;
    model_reset();

    // Frame 0 blank, frame 1 shows 1..6
    run_to_slot(0, 2);
    chk("f0_blank_seg", seg, 7'b1111111);
    run_to_slot(0, 1);
    chk("f1_d1_an", an, 6'b111110);
    chk("f1_d1_seg", seg, 7'b1111001);
    run_to_slot(1, 0);
    chk("f1_blank_slot_an", an, 6'b111111);
    run_to_slot(1, 3);
    chk("f1_d2_an", an, 6'b111101);
    chk("f1_d2_seg", seg, 7'b0100100);
    repeat (50) step();

    // Mid-frame change on d3
    run_to_slot(1, 1);
    d3 = 4'd7;
    run_to_slot(2, 2);
    chk("d3_old_kept", seg, 7'b0110000);
    run_to_slot(2, 2);
    chk("d3_new_shown", seg, 7'b1111000);

    // Glyph table on slot 1
    for (int k = 0; k < 16; k++) begin
      set_all(vecs[k].code);
      run_to_slot(5, 3);
      run_to_slot(1, 2);
      chk("glyph_an", an, 6'b111101);
      chk("glyph_seg", seg, vecs[k].seg);
      chk("glyph_dp", dp, 1'b1);
    end

    // 'E' with ok toggled
    set_all(4'hE);
    run_to_slot(5, 3);
    ok = 1'b1;
    run_to_slot(3, 1);
    chk("ok_dp_lit", dp, 1'b0);
    chk("ok_seg_e", seg, 7'b0000110);
    run_to_slot(4, 0);
    chk("ok_dp_blank", dp, 1'b1);
    ok = 1'b0;

    // Blink: run lit/dark phases, then drop flash while dark
    flash = 1'b1;
    repeat (80) step();
    begin
      int n = 0;
      while (((m_wraps / BD) % 2) == 0 && n < 100) begin step(); n++; end
      chk("flash_dark_reached", (n < 100), 1);
      step();
      chk("flash_dark_an", an, 6'b111111);
    end
    flash = 1'b0;
    repeat (30) step();

    // Async reset mid-slot while digit 5 is lit
    set_all(4'h8);
    run_to_slot(5, 3);
    run_to_slot(4, 2);
    chk("pre_rst_an", an, 6'b101111);
    #2 clr = 1'b0;
    #1;
    chk("async_rst_an", an, 6'b111111);
    chk("async_rst_seg", seg, 7'b1111111);
    chk("async_rst_fd", frame_done, 1'b0);
    @(negedge true_clk);
    clr = 1'b1;
    model_reset();
    run_to_slot(0, 1);
    chk("post_rst_an", an, 6'b111110);
    chk("post_rst_blank", seg, 7'b1111111);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
        d4 = 4'($urandom); d5 = 4'($urandom); d6 = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) ok = ~ok;
      if ($urandom_range(0, 39) == 0) flash = ~flash;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
